regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
Sequencing and arbitration controller for the strobe-driven register file. It runs the register-file clear after reset. It serialises decode-stage operand reads and ALU/LSU writebacks into setup/strobe pulse pairs on the register file's read and write enables, and keeps a 32-entry busy scoreboard so reads stall on pending writes (RAW/WAW). Data buses run directly from ALU/LSU to the register file; this block drives only control and address lines.

Parameters:
RstCycles, 2, cycles rf_rst_o is held high in INIT before falling (the falling edge clears the register file)
AluStarveMax, 3, consecutive LSU write grants while ALU is waiting before ALU is forced to win

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
rd_valid_i  in  1  decode requests an operand read
rd_ready_o  out  1  read accepted (single-cycle pulse, in RD_STROBE)
rd_raddr_a_i  in  5  source A address
rd_use_a_i  in  1  source A is used
rd_raddr_b_i  in  5  source B address
rd_use_b_i  in  1  source B is used
rd_reserve_i  in  1  the instruction will write rd_waddr_i
rd_waddr_i  in  5  destination to reserve
rd_done_o  out  1  rdata_a/b valid at register-file outputs (one-cycle pulse)
wb_alu_valid_i  in  1  ALU writeback pending
wb_alu_addr_i  in  5  ALU destination
wb_alu_ready_o  out  1  ALU writeback committed
wb_lsu_valid_i  in  1  LSU writeback pending
wb_lsu_addr_i  in  5  LSU destination
wb_lsu_ready_o  out  1  LSU writeback committed
rf_en_r_o  out  1  read strobe
rf_en_w_o  out  1  write strobe
rf_req_ra_o  out  1  read port A enable
rf_req_rb_o  out  1  read port B enable
rf_req_w_o  out  1  write enable
rf_raddr_a_o  out  5  read address A
rf_raddr_b_o  out  5  read address B
rf_waddr_o  out  5  write address
rf_soursel_o  out  1  0 = ALU data, 1 = LSU data
rf_rst_o  out  1  register-file clear line
busy_o  out  32  scoreboard
init_done_o  out  1  INIT finished

Behaviour:
- All outputs are registered. Reset values: rf_rst_o=1. All other outputs are 0, busy_o=0, state=INIT.
- States: INIT, IDLE, WR_SETUP, WR_STROBE, RD_SETUP, RD_STROBE.
- INIT: counts RstCycles cycles with rf_rst_o=1, then drives rf_rst_o=0, sets init_done_o=1 and goes to IDLE. No handshakes occur before init_done_o.
- IDLE decision order:
  1. Write pending → WR_SETUP.
  2. Otherwise, an eligible read → RD_SETUP.
  3. Otherwise stay in IDLE.
- Arbitration between writebacks: LSU beats ALU, except when starve_cnt == AluStarveMax and ALU is valid.
  - starve_cnt increments on each LSU grant while wb_alu_valid_i=1.
  - starve_cnt clears on any ALU grant and saturates at AluStarveMax.
- Read eligibility: rd_valid_i=1 and none of the following is busy:
  - (rd_use_a_i ? rd_raddr_a_i : none)
  - (rd_use_b_i ? rd_raddr_b_i : none)
  - (rd_reserve_i ? rd_waddr_i : none)
- Write sequence for a write granted at cycle T:
  - T+1 WR_SETUP: address, soursel and req_w are driven; en_w=0.
  - T+2 WR_STROBE: en_w=1 and the winner's ready=1; busy[addr] clears.
  - T+3: IDLE, en_w=0, req_w=0.
  - The producer must hold data and valid until its ready pulse.
- Read sequence for a read granted at cycle T:
  - T+1 RD_SETUP: addresses driven; req_ra = use_a, req_rb = use_b.
  - T+2 RD_STROBE: en_r=1, rd_ready_o=1; busy[rd_waddr_i] is set if rd_reserve_i.
  - T+3: rd_done_o=1 for one cycle; FSM returns to IDLE.
- Addresses and requests stay stable for the whole SETUP and STROBE window.
- x0 handling:
  - Never marked busy and never stalls a read.
  - A writeback to x0 completes the handshake in the WR_STROBE cycle with rf_req_w_o=0 and en_w still pulsed.
- Write to a non-busy register: performed normally; the scoreboard is unchanged.
- Only one operation is in flight at a time, so busy set and busy clear never coincide.
- Throughput is one operation per 3 cycles. Reads stall indefinitely while writes keep arriving; this is accepted.
- Async reset at any point:
  - Immediately returns to INIT and clears the scoreboard.
  - Drops all strobes and readies, and raises rf_rst_o.
  - An in-flight handshake is abandoned; producers retry after init_done_o.

Test Plan:
- Reset released with RstCycles=2 → rf_rst_o high 2 cycles, then falls; init_done_o=1 the next cycle; no en_r/en_w pulses during INIT.
- ALU wb to x5 with busy[5]=1 → WR_SETUP then WR_STROBE: rf_waddr_o=5, soursel=0, en_w=1 and wb_alu_ready_o=1 in the same cycle; busy[5]=0 afterwards.
- Read with rs1=5 while busy[5]=1, then LSU wb to x5 → read stalls; write commits first; read strobe follows; rd_done_o pulses 3 cycles after the read grant.
- LSU and ALU valid continuously, AluStarveMax=3 → grant order LSU, LSU, LSU, ALU, LSU, ...
- Read with reserve rd=0 and a wb to x0 → busy_o stays 0; wb handshake completes with rf_req_w_o=0.
- rst_i asserted during WR_STROBE → en_w and ready drop immediately, busy_o=0, FSM re-enters INIT.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Sequences register-file clear, operand reads and ALU/LSU writebacks as setup/strobe pulse pairs.
// Latency: grant at T, SETUP at T+1, STROBE (ready pulse) at T+2, rd_done_o at T+3.
// Backpressure: one op in flight, 1 op / 3 cycles; reads stall on busy regs, producers hold valid until ready.
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   rd_*_i / rd_ready_o, rd_done_o operand read request (A/B sources, optional destination reservation)
//   wb_alu_* / wb_lsu_*           writeback requests and commit pulses
//   rf_*_o                        register-file strobes, port enables, addresses, data-source select, clear line
//   busy_o                        per-register pending-write scoreboard (bit 0 is always 0)
//   init_done_o                   clear sequence finished, handshakes allowed
module regfile_access_ctrl #(
  parameter int RstCycles    = 2,
  parameter int AluStarveMax = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_valid_i,
  output logic        rd_ready_o,
  input  logic [4:0]  rd_raddr_a_i,
  input  logic        rd_use_a_i,
  input  logic [4:0]  rd_raddr_b_i,
  input  logic        rd_use_b_i,
  input  logic        rd_reserve_i,
  input  logic [4:0]  rd_waddr_i,
  output logic        rd_done_o,
  input  logic        wb_alu_valid_i,
  input  logic [4:0]  wb_alu_addr_i,
  output logic        wb_alu_ready_o,
  input  logic        wb_lsu_valid_i,
  input  logic [4:0]  wb_lsu_addr_i,
  output logic        wb_lsu_ready_o,
  output logic        rf_en_r_o,
  output logic        rf_en_w_o,
  output logic        rf_req_ra_o,
  output logic        rf_req_rb_o,
  output logic        rf_req_w_o,
  output logic [4:0]  rf_raddr_a_o,
  output logic [4:0]  rf_raddr_b_o,
  output logic [4:0]  rf_waddr_o,
  output logic        rf_soursel_o,
  output logic        rf_rst_o,
  output logic [31:0] busy_o,
  output logic        init_done_o
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR_SETUP,
    WR_STROBE,
    RD_SETUP,
    RD_STROBE
  } state_t;

  localparam int InitCntW = $clog2(RstCycles + 2);
  localparam int StarveW  = $clog2(AluStarveMax + 2);

  state_t              state;
  logic [InitCntW-1:0] init_cnt;
  logic [StarveW-1:0]  starve_cnt;
  logic                rd_reserve_q;
  logic [4:0]          rd_waddr_q;

  logic                wr_pending;
  logic                alu_wins;
  logic [4:0]          wr_addr_sel;
  logic                rd_eligible;

  // Grant decision made in IDLE. busy_o[0] is never set, so x0 never stalls.
  always_comb begin
    wr_pending  = wb_alu_valid_i | wb_lsu_valid_i;
    alu_wins    = wb_alu_valid_i &
                  (~wb_lsu_valid_i | (starve_cnt == StarveW'(AluStarveMax)));
    wr_addr_sel = alu_wins ? wb_alu_addr_i : wb_lsu_addr_i;
    rd_eligible = rd_valid_i
                & ~(rd_use_a_i   & busy_o[rd_raddr_a_i])
                & ~(rd_use_b_i   & busy_o[rd_raddr_b_i])
                & ~(rd_reserve_i & busy_o[rd_waddr_i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= INIT;
      init_cnt       <= '0;
      starve_cnt     <= '0;
      rd_reserve_q   <= 1'b0;
      rd_waddr_q     <= 5'd0;
      rd_ready_o     <= 1'b0;
      rd_done_o      <= 1'b0;
      wb_alu_ready_o <= 1'b0;
      wb_lsu_ready_o <= 1'b0;
      rf_en_r_o      <= 1'b0;
      rf_en_w_o      <= 1'b0;
      rf_req_ra_o    <= 1'b0;
      rf_req_rb_o    <= 1'b0;
      rf_req_w_o     <= 1'b0;
      rf_raddr_a_o   <= 5'd0;
      rf_raddr_b_o   <= 5'd0;
      rf_waddr_o     <= 5'd0;
      rf_soursel_o   <= 1'b0;
      rf_rst_o       <= 1'b1;
      busy_o         <= 32'd0;
      init_done_o    <= 1'b0;
    end else begin
      rd_done_o <= 1'b0;
      case (state)
        INIT: begin
          // The falling edge of rf_rst_o is what clears the register file.
          if (init_cnt == InitCntW'(RstCycles)) begin
            rf_rst_o    <= 1'b0;
            init_done_o <= 1'b1;
            state       <= IDLE;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (wr_pending) begin
            state        <= WR_SETUP;
            rf_waddr_o   <= wr_addr_sel;
            rf_soursel_o <= ~alu_wins;
            // x0 still handshakes and pulses en_w, but never writes.
            rf_req_w_o   <= (wr_addr_sel != 5'd0);
            if (alu_wins) begin
              starve_cnt <= '0;
            end else if (wb_alu_valid_i && (starve_cnt != StarveW'(AluStarveMax))) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (rd_eligible) begin
            state        <= RD_SETUP;
            rf_raddr_a_o <= rd_raddr_a_i;
            rf_raddr_b_o <= rd_raddr_b_i;
            rf_req_ra_o  <= rd_use_a_i;
            rf_req_rb_o  <= rd_use_b_i;
            rd_reserve_q <= rd_reserve_i;
            rd_waddr_q   <= rd_waddr_i;
          end
        end
        WR_SETUP: begin
          state              <= WR_STROBE;
          rf_en_w_o          <= 1'b1;
          wb_alu_ready_o     <= ~rf_soursel_o;
          wb_lsu_ready_o     <= rf_soursel_o;
          busy_o[rf_waddr_o] <= 1'b0;
        end
        WR_STROBE: begin
          state          <= IDLE;
          rf_en_w_o      <= 1'b0;
          rf_req_w_o     <= 1'b0;
          wb_alu_ready_o <= 1'b0;
          wb_lsu_ready_o <= 1'b0;
        end
        RD_SETUP: begin
          state      <= RD_STROBE;
          rf_en_r_o  <= 1'b1;
          rd_ready_o <= 1'b1;
          if (rd_reserve_q && (rd_waddr_q != 5'd0)) begin
            busy_o[rd_waddr_q] <= 1'b1;
          end
        end
        RD_STROBE: begin
          state       <= IDLE;
          rf_en_r_o   <= 1'b0;
          rd_ready_o  <= 1'b0;
          rf_req_ra_o <= 1'b0;
          rf_req_rb_o <= 1'b0;
          rd_done_o   <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl.
// Batches of writebacks and reads are queued, a reference model predicts the strobe order,
// and a negedge monitor compares every strobe, setup cycle, rd_done and scoreboard against it.
module tb_regfile_access_ctrl;

  localparam int RST_CYCLES = 2;
  localparam int STARVE     = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rd_valid_i;
  logic        rd_ready_o;
  logic [4:0]  rd_raddr_a_i;
  logic        rd_use_a_i;
  logic [4:0]  rd_raddr_b_i;
  logic        rd_use_b_i;
  logic        rd_reserve_i;
  logic [4:0]  rd_waddr_i;
  logic        rd_done_o;
  logic        wb_alu_valid_i;
  logic [4:0]  wb_alu_addr_i;
  logic        wb_alu_ready_o;
  logic        wb_lsu_valid_i;
  logic [4:0]  wb_lsu_addr_i;
  logic        wb_lsu_ready_o;
  logic        rf_en_r_o;
  logic        rf_en_w_o;
  logic        rf_req_ra_o;
  logic        rf_req_rb_o;
  logic        rf_req_w_o;
  logic [4:0]  rf_raddr_a_o;
  logic [4:0]  rf_raddr_b_o;
  logic [4:0]  rf_waddr_o;
  logic        rf_soursel_o;
  logic        rf_rst_o;
  logic [31:0] busy_o;
  logic        init_done_o;

  regfile_access_ctrl #(.RstCycles(RST_CYCLES), .AluStarveMax(STARVE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o),
    .rd_raddr_a_i(rd_raddr_a_i), .rd_use_a_i(rd_use_a_i),
    .rd_raddr_b_i(rd_raddr_b_i), .rd_use_b_i(rd_use_b_i),
    .rd_reserve_i(rd_reserve_i), .rd_waddr_i(rd_waddr_i), .rd_done_o(rd_done_o),
    .wb_alu_valid_i(wb_alu_valid_i), .wb_alu_addr_i(wb_alu_addr_i), .wb_alu_ready_o(wb_alu_ready_o),
    .wb_lsu_valid_i(wb_lsu_valid_i), .wb_lsu_addr_i(wb_lsu_addr_i), .wb_lsu_ready_o(wb_lsu_ready_o),
    .rf_en_r_o(rf_en_r_o), .rf_en_w_o(rf_en_w_o),
    .rf_req_ra_o(rf_req_ra_o), .rf_req_rb_o(rf_req_rb_o), .rf_req_w_o(rf_req_w_o),
    .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o), .rf_waddr_o(rf_waddr_o),
    .rf_soursel_o(rf_soursel_o), .rf_rst_o(rf_rst_o), .busy_o(busy_o), .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0] a;
    logic       ua;
    logic [4:0] b;
    logic       ub;
    logic       res;
    logic [4:0] w;
  } rd_req_t;

  // kind: 1 = write strobe, 2 = read strobe
  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  waddr;
    logic        lsu;
    logic        req_w;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        req_ra;
    logic        req_rb;
    logic [31:0] busy;
  } ev_t;

  int total = 0;
  int bad   = 0;

  logic [4:0] alu_q[$];
  logic [4:0] lsu_q[$];
  rd_req_t    rd_q[$];
  ev_t        exp_q[$];

  bit          go_wr = 0;
  bit          go_rd = 0;
  bit          mon_en = 1;
  logic [31:0] m_busy = 32'd0;
  int          m_starve = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rd_req_t mk_rd(input logic [4:0] a, input logic ua, input logic [4:0] b,
                                    input logic ub, input logic res, input logic [4:0] w);
    rd_req_t r;
    r.a = a; r.ua = ua; r.b = b; r.ub = ub; r.res = res; r.w = w;
    return r;
  endfunction

  function automatic bit blocked(input rd_req_t r);
    return (r.ua  && r.a != 5'd0 && m_busy[r.a]) ||
           (r.ub  && r.b != 5'd0 && m_busy[r.b]) ||
           (r.res && r.w != 5'd0 && m_busy[r.w]);
  endfunction

  // Reference model: all queued requests are visible from the first decision on.
  // Writes always go before reads; LSU beats ALU unless ALU has lost STARVE times in a row.
  // A read that could never become eligible is turned into a plain read so the batch drains.
  task automatic model_batch();
    int ia, il, ir;
    bit ap, lp, aw;
    logic [4:0] ad;
    rd_req_t r;
    ev_t e;
    ia = 0; il = 0; ir = 0;
    forever begin
      ap = ia < alu_q.size();
      lp = il < lsu_q.size();
      e  = '0;
      if (ap || lp) begin
        aw = ap && (!lp || m_starve == STARVE);
        if (aw) begin
          ad = alu_q[ia]; ia++; m_starve = 0;
        end else begin
          ad = lsu_q[il]; il++;
          if (ap && m_starve < STARVE) m_starve++;
        end
        m_busy[ad] = 1'b0;
        e.kind = 2'd1; e.waddr = ad; e.lsu = !aw; e.req_w = (ad != 5'd0);
      end else if (ir < rd_q.size()) begin
        r = rd_q[ir];
        if (blocked(r)) begin
          r.ua = 1'b0; r.ub = 1'b0; r.res = 1'b0;
          rd_q[ir] = r;
        end
        ir++;
        if (r.res && r.w != 5'd0) m_busy[r.w] = 1'b1;
        e.kind = 2'd2; e.ra = r.a; e.rb = r.b; e.req_ra = r.ua; e.req_rb = r.ub;
      end else begin
        break;
      end
      e.busy = m_busy;
      exp_q.push_back(e);
    end
  endtask

  // Producer / decode driver: present queue heads, pop on the ready pulse.
  initial begin
    rd_valid_i = 0; rd_raddr_a_i = 0; rd_use_a_i = 0; rd_raddr_b_i = 0; rd_use_b_i = 0;
    rd_reserve_i = 0; rd_waddr_i = 0;
    wb_alu_valid_i = 0; wb_alu_addr_i = 0; wb_lsu_valid_i = 0; wb_lsu_addr_i = 0;
    forever begin
      @(posedge clk_i); #1;
      if (wb_alu_ready_o && alu_q.size() > 0) void'(alu_q.pop_front());
      if (wb_lsu_ready_o && lsu_q.size() > 0) void'(lsu_q.pop_front());
      if (rd_ready_o && rd_q.size() > 0) void'(rd_q.pop_front());
      wb_alu_valid_i = go_wr && alu_q.size() > 0;
      wb_alu_addr_i  = (alu_q.size() > 0) ? alu_q[0] : 5'd0;
      wb_lsu_valid_i = go_wr && lsu_q.size() > 0;
      wb_lsu_addr_i  = (lsu_q.size() > 0) ? lsu_q[0] : 5'd0;
      rd_valid_i     = go_rd && rd_q.size() > 0;
      if (rd_q.size() > 0) begin
        rd_raddr_a_i = rd_q[0].a; rd_use_a_i = rd_q[0].ua;
        rd_raddr_b_i = rd_q[0].b; rd_use_b_i = rd_q[0].ub;
        rd_reserve_i = rd_q[0].res; rd_waddr_i = rd_q[0].w;
      end
    end
  end

  // Monitor: compares every strobe (and the setup cycle before it) against the model.
  logic        p_en_w = 0, p_en_r = 0, p_req_w = 0, p_sel = 0, p_req_ra = 0, p_req_rb = 0;
  logic [4:0]  p_waddr = 0, p_ra = 0, p_rb = 0;
  bit          busy_pend = 0;
  logic [31:0] exp_busy = 0;
  always @(negedge clk_i) begin
    ev_t e;
    int kn, ke;
    if (mon_en) begin
      if (busy_pend) begin
        chk("busy_after_op", busy_o, exp_busy);
        busy_pend = 0;
      end
      if (rd_done_o || p_en_r) chk("rd_done_after_strobe", rd_done_o, p_en_r);
      if (rf_en_w_o || rf_en_r_o) begin
        kn = rf_en_w_o ? 1 : 2;
        ke = (exp_q.size() == 0) ? 0 : int'(exp_q[0].kind);
        chk("strobe_kind", kn, ke);
        if (kn == ke) begin
          e = exp_q.pop_front();
          if (kn == 1) begin
            chk("wr_strobe", {rf_waddr_o, rf_soursel_o, rf_req_w_o, wb_alu_ready_o, wb_lsu_ready_o, rf_en_r_o},
                {e.waddr, e.lsu, e.req_w, !e.lsu, e.lsu, 1'b0});
            chk("wr_setup", {p_en_w, p_waddr, p_sel, p_req_w}, {1'b0, e.waddr, e.lsu, e.req_w});
          end else begin
            chk("rd_strobe", {rf_raddr_a_o, rf_raddr_b_o, rf_req_ra_o, rf_req_rb_o, rd_ready_o, rf_req_w_o},
                {e.ra, e.rb, e.req_ra, e.req_rb, 1'b1, 1'b0});
            chk("rd_setup", {p_en_r, p_ra, p_rb, p_req_ra, p_req_rb}, {1'b0, e.ra, e.rb, e.req_ra, e.req_rb});
          end
          exp_busy = e.busy;
          busy_pend = 1;
        end
      end
    end else begin
      busy_pend = 0;
    end
    p_en_w = rf_en_w_o; p_en_r = rf_en_r_o; p_req_w = rf_req_w_o; p_sel = rf_soursel_o;
    p_waddr = rf_waddr_o; p_ra = rf_raddr_a_o; p_rb = rf_raddr_b_o;
    p_req_ra = rf_req_ra_o; p_req_rb = rf_req_rb_o;
  end

  task automatic check_init();
    for (int i = 0; i < RST_CYCLES; i++) begin
      @(posedge clk_i); #1;
      chk("init_hold", {rf_rst_o, init_done_o, rf_en_r_o, rf_en_w_o}, 4'b1000);
    end
    @(posedge clk_i); #1;
    chk("init_release", {rf_rst_o, init_done_o, rf_en_r_o, rf_en_w_o}, 4'b0100);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((alu_q.size() + lsu_q.size() + rd_q.size() + exp_q.size()) != 0 && n < budget) begin
      @(posedge clk_i); #2;
      n++;
    end
    chk("batch_drain_left", exp_q.size(), 0);
    if (n >= budget) begin
      alu_q.delete(); lsu_q.delete(); rd_q.delete(); exp_q.delete();
    end
    repeat (3) @(posedge clk_i);
    #2;
  endtask

  task automatic run_batch(input bit stagger);
    model_batch();
    go_rd = 1;
    if (stagger) begin
      repeat (8) @(posedge clk_i);
      #2;
    end
    go_wr = 1;
    wait_done(600);
    go_rd = 0;
    go_wr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nl, nr, n;
    rst_i = 1'b1;
    #3;
    chk("reset_values", {rf_rst_o, init_done_o, rf_en_r_o, rf_en_w_o, rd_ready_o, rd_done_o,
                         wb_alu_ready_o, wb_lsu_ready_o, rf_req_ra_o, rf_req_rb_o, rf_req_w_o, rf_soursel_o},
        12'b1000_0000_0000);
    chk("reset_busy", busy_o, 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    check_init();

    // Reserve x5, then an ALU writeback to busy x5 must clear it.
    rd_q.push_back(mk_rd(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5));
    run_batch(0);
    chk("busy5_set", busy_o, m_busy);
    alu_q.push_back(5'd5);
    run_batch(0);
    chk("busy5_cleared", busy_o, m_busy);

    // Read of busy x5 stalls until a late LSU writeback commits.
    rd_q.push_back(mk_rd(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5));
    run_batch(0);
    rd_q.push_back(mk_rd(5'd5, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0));
    lsu_q.push_back(5'd5);
    run_batch(1);

    // Both writeback sources continuously valid: ALU forced through after STARVE LSU wins.
    for (int k = 1; k <= 7; k++) lsu_q.push_back(5'(k));
    alu_q.push_back(5'd8);
    alu_q.push_back(5'd9);
    run_batch(0);

    // x0: no reservation, write handshakes with req_w low.
    rd_q.push_back(mk_rd(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0));
    alu_q.push_back(5'd0);
    run_batch(0);
    chk("x0_busy", busy_o, 32'd0);

    // Randomised batches with a small address range to force hazards.
    for (int bi = 0; bi < 25; bi++) begin
      na = $urandom_range(0, 3);
      nl = $urandom_range(0, 3);
      nr = $urandom_range(0, 3);
      for (int k = 0; k < na; k++) alu_q.push_back(5'($urandom_range(0, 7)));
      for (int k = 0; k < nl; k++) lsu_q.push_back(5'($urandom_range(0, 7)));
      for (int k = 0; k < nr; k++)
        rd_q.push_back(mk_rd(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))));
      run_batch(0);
      chk("rand_busy", busy_o, m_busy);
    end

    // Async reset in the middle of a write strobe.
    alu_q.push_back(5'd4);
    lsu_q.push_back(5'd3);
    lsu_q.push_back(5'd6);
    run_batch(0);
    rd_q.push_back(mk_rd(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3));
    rd_q.push_back(mk_rd(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6));
    run_batch(0);
    chk("pre_reset_busy", busy_o, m_busy);
    mon_en = 0;
    alu_q.push_back(5'd3);
    go_wr = 1;
    n = 0;
    while (!rf_en_w_o && n < 50) begin
      @(posedge clk_i); #2;
      n++;
    end
    chk("strobe_reached", rf_en_w_o, 1'b1);
    chk("busy6_in_strobe", busy_o[6], 1'b1);
    rst_i = 1'b1;
    #1;
    chk("reset_drops_strobe", {rf_en_w_o, wb_alu_ready_o, wb_lsu_ready_o, rf_req_w_o, rf_rst_o, init_done_o},
        6'b000010);
    chk("reset_clears_busy", busy_o, 32'd0);
    go_wr = 0; go_rd = 0;
    alu_q.delete(); lsu_q.delete(); rd_q.delete(); exp_q.delete();
    wb_alu_valid_i = 0; wb_lsu_valid_i = 0; rd_valid_i = 0;
    m_busy = 32'd0; m_starve = 0;
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    check_init();
    mon_en = 1;
    alu_q.push_back(5'd3);
    rd_q.push_back(mk_rd(5'd3, 1'b1, 5'd6, 1'b1, 1'b1, 5'd7));
    run_batch(0);
    chk("post_reset_busy", busy_o, m_busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
